// File: rtl/erosion_pkg.sv
// ----------------------------------------------------------------------------
// erosion_pkg
// Shared definitions for the erosion line-buffer scheduler:
//   - state_t : scheduler state encoding (IDLE=0 .. DRAIN=4)
//   - DEF_IMG_WIDTH / DEF_IMG_HEIGHT : default frame geometry
//   - clog2   : ceiling log2 helper for sizing counters
// ----------------------------------------------------------------------------
package erosion_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ROW0  = 3'd1,
      ROW1  = 3'd2,
      RUN   = 3'd3,
      DRAIN = 3'd4
   } state_t;

   localparam int unsigned DEF_IMG_WIDTH  = 640;
   localparam int unsigned DEF_IMG_HEIGHT = 480;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/erosion_lb_cnt.sv
// ----------------------------------------------------------------------------
// erosion_lb_cnt
// Column/row position counter for the line-buffer scheduler.
// Ports:
//   clk, rst          clock, async active-high reset
//   clr               synchronous clear of both counters
//   inc               advance column by one (wraps at IMG_WIDTH-1, bumping row)
//   col_cnt, row_cnt  current column / row
//   last_col          col_cnt == IMG_WIDTH-1
//   last_row          row_cnt == IMG_HEIGHT-1
// ----------------------------------------------------------------------------
module erosion_lb_cnt
   import erosion_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int unsigned COL_W      = 11,
   parameter int unsigned ROW_W      = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [COL_W-1:0] col_cnt,
   output logic [ROW_W-1:0] row_cnt,
   output logic             last_col,
   output logic             last_row
);

   assign last_col = (col_cnt == COL_W'(IMG_WIDTH - 1));
   assign last_row = (row_cnt == ROW_W'(IMG_HEIGHT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (clr) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (inc) begin
         if (last_col) begin
            col_cnt <= '0;
            // Row wraps too so the drain phase (which keeps counting columns)
            // can never overflow the row register.
            row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
         end else begin
            col_cnt <= col_cnt + COL_W'(1);
         end
      end
   end

endmodule

// File: rtl/erosion_lb_sched.sv
// ----------------------------------------------------------------------------
// erosion_lb_sched
// Schedules writes/reads of the two binary line-buffer FIFOs feeding the 3x3
// erosion kernel, producing one aligned column {row-2, row-1, row} per pixel
// from the third line on. Both FIFOs are drained at end of frame.
// Ports:
//   clk, rst                      clock, async active-high reset
//   frame_start                   start pulse (accepted in IDLE only)
//   pix_vld, pix_bin              incoming binary pixel
//   lb0_* / lb1_*                 FIFO0 (previous line) / FIFO1 (line before)
//                                 write, read, data and flag ports
//   win_vld, win_col              column vector out, bit 2 = oldest row
//   win_col_idx, win_row_idx      column and center row of win_col
//   win_hborder                   column is first or last of the line
//   busy                          scheduler not idle
//   err_sync, err_ovf, err_udf    sticky protocol / overflow / underflow errors
// ----------------------------------------------------------------------------
module erosion_lb_sched
   import erosion_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int unsigned COL_W      = 11,
   parameter int unsigned ROW_W      = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             pix_vld,
   input  logic             pix_bin,
   output logic             lb0_w_en,
   output logic             lb0_wdata,
   output logic             lb0_r_en,
   input  logic             lb0_rdata,
   input  logic             lb0_wfull,
   input  logic             lb0_rempty,
   output logic             lb1_w_en,
   output logic             lb1_wdata,
   output logic             lb1_r_en,
   input  logic             lb1_rdata,
   input  logic             lb1_wfull,
   input  logic             lb1_rempty,
   output logic             win_vld,
   output logic [2:0]       win_col,
   output logic [COL_W-1:0] win_col_idx,
   output logic [ROW_W-1:0] win_row_idx,
   output logic             win_hborder,
   output logic             busy,
   output logic             err_sync,
   output logic             err_ovf,
   output logic             err_udf
);

   state_t           state_q, state_d;
   logic             accept;
   logic             cnt_clr;
   logic             cnt_inc;
   logic [COL_W-1:0] col_cnt;
   logic [ROW_W-1:0] row_cnt;
   logic             last_col;
   logic             last_row;

   // Stage 1: pixel accepted last cycle; FIFO read data is valid now.
   logic             s1_vld;
   logic             s1_pix;
   logic [COL_W-1:0] s1_col;
   logic [ROW_W-1:0] s1_row;
   logic             s1_hb;
   logic             lb1_w_en_q;

   assign accept  = pix_vld && ((state_q == ROW0) || (state_q == ROW1) || (state_q == RUN));
   assign cnt_clr = frame_start && (state_q == IDLE);
   // DRAIN reuses the column counter to time its IMG_WIDTH read cycles.
   assign cnt_inc = accept || (state_q == DRAIN);
   assign busy    = (state_q != IDLE);

   erosion_lb_cnt #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT),
      .COL_W      (COL_W),
      .ROW_W      (ROW_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .inc      (cnt_inc),
      .col_cnt  (col_cnt),
      .row_cnt  (row_cnt),
      .last_col (last_col),
      .last_row (last_row)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      lb0_w_en  = 1'b0;
      lb0_wdata = 1'b0;
      lb0_r_en  = 1'b0;
      lb1_r_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_start) state_d = ROW0;
         end
         ROW0: begin
            if (pix_vld) begin
               lb0_w_en  = 1'b1;
               lb0_wdata = pix_bin;
               if (last_col) state_d = ROW1;
            end
         end
         ROW1: begin
            if (pix_vld) begin
               lb0_w_en  = 1'b1;
               lb0_wdata = pix_bin;
               lb0_r_en  = 1'b1;
               if (last_col) state_d = RUN;
            end
         end
         RUN: begin
            if (pix_vld) begin
               lb0_w_en  = 1'b1;
               lb0_wdata = pix_bin;
               lb0_r_en  = 1'b1;
               lb1_r_en  = 1'b1;
               if (last_col && last_row) state_d = DRAIN;
            end
         end
         DRAIN: begin
            lb0_r_en = 1'b1;
            lb1_r_en = 1'b1;
            if (last_col) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The enable is registered; the data is the FIFO0 read word that becomes
   // valid in that same cycle, so it is passed straight through (gated to 0
   // while idle) rather than registered a second time.
   assign lb1_w_en  = lb1_w_en_q;
   assign lb1_wdata = lb1_w_en_q ? lb0_rdata : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lb1_w_en_q <= 1'b0;
         s1_vld     <= 1'b0;
         s1_pix     <= 1'b0;
         s1_col     <= '0;
         s1_row     <= '0;
         s1_hb      <= 1'b0;
      end else begin
         lb1_w_en_q <= accept && ((state_q == ROW1) || (state_q == RUN));
         s1_vld     <= accept && (state_q == RUN);
         if (accept && (state_q == RUN)) begin
            s1_pix <= pix_bin;
            s1_col <= col_cnt;
            s1_row <= row_cnt - ROW_W'(1);
            s1_hb  <= (col_cnt == '0) || last_col;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_vld     <= 1'b0;
         win_col     <= '0;
         win_col_idx <= '0;
         win_row_idx <= '0;
         win_hborder <= 1'b0;
      end else begin
         win_vld <= s1_vld;
         if (s1_vld) begin
            win_col     <= {lb1_rdata, lb0_rdata, s1_pix};
            win_col_idx <= s1_col;
            win_row_idx <= s1_row;
            win_hborder <= s1_hb;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sync <= 1'b0;
         err_ovf  <= 1'b0;
         err_udf  <= 1'b0;
      end else begin
         if ((frame_start && (state_q != IDLE)) ||
             (pix_vld && ((state_q == IDLE) || (state_q == DRAIN))))
            err_sync <= 1'b1;
         if ((lb0_w_en && lb0_wfull) || (lb1_w_en && lb1_wfull))
            err_ovf <= 1'b1;
         if ((lb0_r_en && lb0_rempty) || (lb1_r_en && lb1_rempty))
            err_udf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_erosion_lb_sched.sv
module tb_erosion_lb_sched;

   localparam int W     = 8;
   localparam int H     = 4;
   localparam int CW    = 4;
   localparam int RW    = 3;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_start, pix_vld, pix_bin;
   logic          lb0_w_en, lb0_wdata, lb0_r_en, lb0_rdata, lb0_wfull, lb0_rempty;
   logic          lb1_w_en, lb1_wdata, lb1_r_en, lb1_rdata, lb1_wfull, lb1_rempty;
   logic          win_vld, win_hborder, busy, err_sync, err_ovf, err_udf;
   logic [2:0]    win_col;
   logic [CW-1:0] win_col_idx;
   logic [RW-1:0] win_row_idx;
   logic          frc_wfull0 = 1'b0;
   logic          frc_rempty1 = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int win_cnt = 0;

   typedef struct {
      logic [2:0]    col;
      logic [CW-1:0] cidx;
      logic [RW-1:0] ridx;
      logic          hb;
      int            cyc;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   typedef struct {
      int gap;
      int pat;
      int exp_wins;
      int exp_drain;
   } vec_t;
   vec_t tbl[4];

   logic img[H][W];

   erosion_lb_sched #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .COL_W      (CW),
      .ROW_W      (RW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .pix_vld     (pix_vld),
      .pix_bin     (pix_bin),
      .lb0_w_en    (lb0_w_en),
      .lb0_wdata   (lb0_wdata),
      .lb0_r_en    (lb0_r_en),
      .lb0_rdata   (lb0_rdata),
      .lb0_wfull   (lb0_wfull),
      .lb0_rempty  (lb0_rempty),
      .lb1_w_en    (lb1_w_en),
      .lb1_wdata   (lb1_wdata),
      .lb1_r_en    (lb1_r_en),
      .lb1_rdata   (lb1_rdata),
      .lb1_wfull   (lb1_wfull),
      .lb1_rempty  (lb1_rempty),
      .win_vld     (win_vld),
      .win_col     (win_col),
      .win_col_idx (win_col_idx),
      .win_row_idx (win_row_idx),
      .win_hborder (win_hborder),
      .busy        (busy),
      .err_sync    (err_sync),
      .err_ovf     (err_ovf),
      .err_udf     (err_udf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous FIFO models, reset by the same rst as the DUT.
   logic [1:0] f_we, f_re, f_wd, f_rd;
   int         f_cnt[2];
   int         f_wp[2];
   int         f_rp[2];
   logic       f_mem[2][DEPTH];

   assign f_we = {lb1_w_en, lb0_w_en};
   assign f_re = {lb1_r_en, lb0_r_en};
   assign f_wd = {lb1_wdata, lb0_wdata};
   assign lb0_rdata  = f_rd[0];
   assign lb1_rdata  = f_rd[1];
   assign lb0_rempty = (f_cnt[0] == 0);
   assign lb0_wfull  = (f_cnt[0] == DEPTH) || frc_wfull0;
   assign lb1_rempty = (f_cnt[1] == 0) || frc_rempty1;
   assign lb1_wfull  = (f_cnt[1] == DEPTH);

   always @(posedge clk or posedge rst) begin : fifo_models
      bit do_r, do_w;
      if (rst) begin
         f_rd <= '0;
         for (int i = 0; i < 2; i++) begin
            f_cnt[i] <= 0;
            f_wp[i]  <= 0;
            f_rp[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            do_r = f_re[i] && (f_cnt[i] != 0);
            do_w = f_we[i] && ((f_cnt[i] != DEPTH) || do_r);
            if (do_r) begin
               f_rd[i] <= f_mem[i][f_rp[i]];
               f_rp[i] <= (f_rp[i] + 1) % DEPTH;
            end
            if (do_w) begin
               f_mem[i][f_wp[i]] <= f_wd[i];
               f_wp[i] <= (f_wp[i] + 1) % DEPTH;
            end
            f_cnt[i] <= f_cnt[i] + (do_w ? 1 : 0) - (do_r ? 1 : 0);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Output monitor: pops the scoreboard for every column vector.
   always @(negedge clk) begin
      if (!rst && win_vld) begin
         win_cnt++;
         if (sb.size() == 0) begin
            check("win_unexpected", 64'(win_col_idx), 64'hFFFF);
         end else begin
            mon_e = sb.pop_front();
            check("win_data", {win_col, win_col_idx, win_row_idx, win_hborder},
                  {mon_e.col, mon_e.cidx, mon_e.ridx, mon_e.hb});
            check("win_latency", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   task automatic drive_idle();
      @(posedge clk); #1;
      pix_vld = 1'b0; frame_start = 1'b0; frc_wfull0 = 1'b0; frc_rempty1 = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      check(name, {win_vld, win_col, win_col_idx, win_row_idx, win_hborder, busy,
                   err_sync, err_ovf, err_udf, lb0_w_en, lb0_wdata, lb0_r_en,
                   lb1_w_en, lb1_wdata, lb1_r_en}, 64'd0);
   endtask

   // One frame; the *_at arguments are pixel indices for injected events (-1 none).
   task automatic run_frame(input int gap, input int pat, input int fs_at, input int ovf_at,
                            input int udf_at, input int rst_at,
                            input int exp_wins, input int exp_drain);
      int r, c, dcnt;
      bit done;
      win_cnt = 0;
      for (int rr = 0; rr < H; rr++)
         for (int cc = 0; cc < W; cc++)
            case (pat)
               0:       img[rr][cc] = logic'(cc & 1);
               1:       img[rr][cc] = logic'((rr ^ cc) & 1);
               default: img[rr][cc] = logic'($urandom_range(0, 1));
            endcase
      @(posedge clk); #1;
      frame_start = 1'b1; pix_vld = 1'b0;
      for (int idx = 0; idx < W * H; idx++) begin
         r = idx / W;
         c = idx % W;
         @(posedge clk); #1;
         if (idx == rst_at) begin
            rst = 1'b1; pix_vld = 1'b0; frame_start = 1'b0;
            sb.delete();
            @(negedge clk);
            check_all_zero("rst_midframe_outputs");
            check("rst_fifos_empty", {lb0_rempty, lb1_rempty}, 2'b11);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         frame_start = (idx == fs_at);
         frc_wfull0  = (idx == ovf_at);
         frc_rempty1 = (idx == udf_at);
         pix_vld = 1'b1;
         pix_bin = img[r][c];
         if (r >= 2)
            sb.push_back('{col: {img[r-2][c], img[r-1][c], img[r][c]}, cidx: CW'(c),
                           ridx: RW'(r - 1), hb: logic'((c == 0) || (c == W - 1)),
                           cyc: cyc + 2});
         if (idx != W * H - 1)
            repeat (gap) drive_idle();
      end
      drive_idle();
      dcnt = 0;
      done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
         else if (lb0_r_en && lb1_r_en && !lb0_w_en) dcnt++;
      end
      check("drain_done", 64'(done), 64'd1);
      check("drain_len", 64'(dcnt), 64'(exp_drain));
      check("fifos_empty", {lb0_rempty, lb1_rempty}, 2'b11);
      check("win_count", 64'(win_cnt), 64'(exp_wins));
      check("sb_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      tbl[0] = '{gap: 0, pat: 0, exp_wins: 16, exp_drain: W};
      tbl[1] = '{gap: 1, pat: 0, exp_wins: 16, exp_drain: W};
      tbl[2] = '{gap: 0, pat: 1, exp_wins: 16, exp_drain: W};
      tbl[3] = '{gap: 2, pat: 2, exp_wins: 16, exp_drain: W};

      rst = 1'b1; frame_start = 1'b0; pix_vld = 1'b0; pix_bin = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset_outputs");
      check("reset_fifos_empty", {lb0_rempty, lb1_rempty}, 2'b11);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int unsigned i = 0; i < 4; i++) begin
         run_frame(tbl[i].gap, tbl[i].pat, -1, -1, -1, -1, tbl[i].exp_wins, tbl[i].exp_drain);
         check("errs_clean", {err_sync, err_ovf, err_udf}, 3'b000);
      end

      // pix_vld while idle is ignored and flagged.
      @(posedge clk); #1;
      pix_vld = 1'b1; pix_bin = 1'b1;
      @(negedge clk);
      check("idle_pix_no_write", 64'(lb0_w_en), 64'd0);
      drive_idle();
      @(negedge clk);
      check("idle_pix_err_sync", {err_sync, busy}, 2'b10);

      // frame_start during RUN: flagged, frame continues with unchanged counters.
      run_frame(0, 1, 2 * W + 1, -1, -1, -1, 16, W);
      check("run_fs_err_sync", {err_sync, err_ovf, err_udf}, 3'b100);

      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("errs_cleared_by_rst", {err_sync, err_ovf, err_udf}, 3'b000);

      // Forced full during ROW0 and forced empty during RUN.
      run_frame(0, 2, -1, 2, 2 * W + 5, -1, 16, W);
      check("ovf_udf_set", {err_sync, err_ovf, err_udf}, 3'b011);
      repeat (5) drive_idle();
      @(negedge clk);
      check("ovf_udf_sticky", {err_sync, err_ovf, err_udf}, 3'b011);

      // Reset at row 2 col 3, then a clean frame.
      run_frame(0, 0, -1, -1, -1, 2 * W + 3, 0, 0);
      run_frame(1, 1, -1, -1, -1, -1, 16, W);
      check("post_rst_errs_clean", {err_sync, err_ovf, err_udf}, 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
